// File: rtl/id_cond_decode.sv
// Decode stage: ARM instruction -> registered execute command/controls, NZCV register, condition squash.
// Build option COND_BYPASS_EN: evaluate conditions against alu_status when status_we is high.
module id_cond_decode #(
   parameter int unsigned CMD_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             instr_valid,
   input  logic [31:0]      instr,
   input  logic             freeze,
   input  logic             flush,
   input  logic             status_we,
   input  logic [3:0]       alu_status,
   output logic [3:0]       status_q,
   output logic [CMD_W-1:0] exe_cmd,
   output logic             wb_en,
   output logic             mem_r_en,
   output logic             mem_w_en,
   output logic             b,
   output logic             s,
   output logic             imm,
   output logic             out_valid
);

   localparam int unsigned COND_W = 4;
   localparam int unsigned OPC_W  = 4;

   logic [COND_W-1:0] cond;
   logic [1:0]        mode;
   logic [OPC_W-1:0]  opcode;
   logic              sl_bit;

   assign cond   = instr[31:28];
   assign mode   = instr[27:26];
   assign opcode = instr[24:21];
   assign sl_bit = instr[20];

   logic [CMD_W-1:0] dec_cmd;
   logic             dec_wb;
   logic             dec_mr;
   logic             dec_mw;
   logic             dec_b;
   logic             dec_s;
   logic             dec_ok;

   // Instruction decode; dec_ok clears for unsupported mode/opcode
   always_comb begin
      dec_cmd = '0;
      dec_wb  = 1'b0;
      dec_mr  = 1'b0;
      dec_mw  = 1'b0;
      dec_b   = 1'b0;
      dec_s   = 1'b0;
      dec_ok  = 1'b0;
      case (mode)
         2'b00: begin
            dec_ok = 1'b1;
            dec_wb = 1'b1;
            dec_s  = sl_bit;
            case (opcode)
               4'b1101: dec_cmd = CMD_W'(1);
               4'b1111: dec_cmd = CMD_W'(9);
               4'b0100: dec_cmd = CMD_W'(2);
               4'b0101: dec_cmd = CMD_W'(3);
               4'b0010: dec_cmd = CMD_W'(4);
               4'b0110: dec_cmd = CMD_W'(5);
               4'b0000: dec_cmd = CMD_W'(6);
               4'b1100: dec_cmd = CMD_W'(7);
               4'b0001: dec_cmd = CMD_W'(8);
               4'b1010: begin
                  dec_cmd = CMD_W'(4);
                  dec_wb  = 1'b0;
                  dec_s   = 1'b1;
               end
               4'b1000: begin
                  dec_cmd = CMD_W'(6);
                  dec_wb  = 1'b0;
                  dec_s   = 1'b1;
               end
               default: begin
                  dec_ok = 1'b0;
                  dec_wb = 1'b0;
                  dec_s  = 1'b0;
               end
            endcase
         end
         2'b01: begin
            dec_ok  = 1'b1;
            dec_cmd = CMD_W'(2);
            dec_mr  = sl_bit;
            dec_mw  = ~sl_bit;
            dec_wb  = sl_bit;
         end
         2'b10: begin
            dec_ok = 1'b1;
            dec_b  = 1'b1;
         end
         default: dec_ok = 1'b0;
      endcase
   end

   logic [3:0] eff_status;
`ifdef COND_BYPASS_EN
   assign eff_status = status_we ? alu_status : status_q;
`else
   assign eff_status = status_q;
`endif

   logic flag_n, flag_z, flag_c, flag_v;
   assign {flag_n, flag_z, flag_c, flag_v} = eff_status;

   logic cond_pass;

   // Condition field evaluation against effective NZCV
   always_comb begin
      cond_pass = 1'b0;
      case (cond)
         4'b0000: cond_pass = flag_z;
         4'b0001: cond_pass = ~flag_z;
         4'b0010: cond_pass = flag_c;
         4'b0011: cond_pass = ~flag_c;
         4'b0100: cond_pass = flag_n;
         4'b0101: cond_pass = ~flag_n;
         4'b0110: cond_pass = flag_v;
         4'b0111: cond_pass = ~flag_v;
         4'b1000: cond_pass = flag_c & ~flag_z;
         4'b1001: cond_pass = ~flag_c | flag_z;
         4'b1010: cond_pass = (flag_n == flag_v);
         4'b1011: cond_pass = (flag_n != flag_v);
         4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
         4'b1101: cond_pass = flag_z | (flag_n != flag_v);
         4'b1110: cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   end

   logic load;
   assign load = instr_valid & dec_ok & cond_pass;

   // Status register runs independently of freeze/flush; output register has flush > freeze > load
   always_ff @(posedge clk) begin
      if (rst) begin
         status_q  <= '0;
         exe_cmd   <= '0;
         wb_en     <= 1'b0;
         mem_r_en  <= 1'b0;
         mem_w_en  <= 1'b0;
         b         <= 1'b0;
         s         <= 1'b0;
         imm       <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         if (status_we) status_q <= alu_status;
         if (flush || (!freeze && !load)) begin
            exe_cmd   <= '0;
            wb_en     <= 1'b0;
            mem_r_en  <= 1'b0;
            mem_w_en  <= 1'b0;
            b         <= 1'b0;
            s         <= 1'b0;
            imm       <= 1'b0;
            out_valid <= 1'b0;
         end else if (!freeze) begin
            exe_cmd   <= dec_cmd;
            wb_en     <= dec_wb;
            mem_r_en  <= dec_mr;
            mem_w_en  <= dec_mw;
            b         <= dec_b;
            s         <= dec_s;
            imm       <= instr[25];
            out_valid <= 1'b1;
         end
      end
   end

endmodule
